// File: rtl/multicycle_control_pkg.sv
// Shared constants and types for the multicycle MIPS-style control unit.
// Holds the state encodings, the supported opcode values, the ALUOp /
// ALUSrcB / PCSource codes and the packed control-vector type, so the
// datapath, the controller and the benches all agree on one definition.
package multicycle_control_pkg;

    // Controller state encodings (4-bit, kept as plain constants so the
    // debug 'state' port keeps its legacy numeric values).
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_EXECUTE   = 4'd7;
    localparam logic [3:0] S_R_WB      = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JUMP      = 4'd10;

    // Supported opcodes (IR[31:26]).
    localparam logic [5:0] R_TYPE = 6'd0;
    localparam logic [5:0] LW     = 6'd35;
    localparam logic [5:0] SW     = 6'd43;
    localparam logic [5:0] BEQ    = 6'd4;
    localparam logic [5:0] J      = 6'd2;

    // ALUOp codes.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUSrcB codes.
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PCSource codes.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Complete set of datapath controls driven from the current state.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

    // True for the opcodes this controller knows how to sequence.
    function automatic logic is_supported(input logic [5:0] op);
        return (op == R_TYPE) || (op == LW) || (op == SW) ||
               (op == BEQ) || (op == J);
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Purely combinational state-to-control-vector decoder.
// Ports:
//   state     - current controller state
//   mem_ready - effective memory-ready (only consulted in FETCH)
//   ctrl      - full datapath control vector; every field not explicitly
//               set for a state is 0
module multicycle_control_decode
    import multicycle_control_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ior_d     = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR and PC only update on the cycle the fetch completes.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control unit (lw, sw, R-type, beq, j).
// Parameters:
//   MEM_WAIT_EN - 1: memory states stall until mem_ready; 0: mem_ready
//                 is treated as always 1
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   op_code      - IR[31:26], sampled only in DECODE and MEM_ADDR
//   mem_ready    - memory completed the current access this cycle
//   PCWrite .. RegDst, ALUOp, ALUSrcB, PCSource - datapath controls
//   state        - current state encoding (debug)
//   illegal_op   - high during the DECODE cycle of an unsupported opcode
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op_code,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       illegal_op
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       mem_rdy;
    ctrl_t      ctrl;

    assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     state_d = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_code)
                    LW, SW:  state_d = S_MEM_ADDR;
                    R_TYPE:  state_d = S_EXECUTE;
                    BEQ:     state_d = S_BRANCH;
                    J:       state_d = S_JUMP;
                    default: state_d = S_FETCH;
                endcase
            end
            // An opcode that changed to neither lw nor sw since DECODE
            // abandons the access rather than guessing a direction.
            S_MEM_ADDR: begin
                if      (op_code == LW) state_d = S_MEM_READ;
                else if (op_code == SW) state_d = S_MEM_WRITE;
                else                    state_d = S_FETCH;
            end
            S_MEM_READ:  state_d = mem_rdy ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_rdy ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            default:     state_d = S_IDLE;
        endcase
    end

    multicycle_control_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_rdy),
        .ctrl      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.ior_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign IRWrite     = ctrl.ir_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign state       = state_q;
    assign illegal_op  = (state_q == S_DECODE) && !is_supported(op_code);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control. Each instruction
// is expanded into its expected cycle-by-cycle trace (state, mem_ready,
// op_code) from the instruction's latency and stall counts; the DUT state
// and control outputs are compared against that trace on every cycle.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] op_code;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0] ALUOp, ALUSrcB, PCSource;
    logic [3:0] state;
    logic       illegal_op;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_code     (op_code),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUOp       (ALUOp),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .state       (state),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         st;
        bit         rdy;
        logic [5:0] op;
    } step_t;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd2};
    endfunction

    // Observed controls packed as
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,
    //  RegWrite,RegDst,ALUOp,ALUSrcB,PCSource,illegal_op}
    function automatic logic [16:0] observed();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                IRWrite, ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB,
                PCSource, illegal_op};
    endfunction

    // Expected controls straight from the per-state output table.
    function automatic logic [16:0] expected(input int st, input bit rdy,
                                             input logic [5:0] op);
        bit pw = 0, pwc = 0, iord = 0, mr = 0, mw = 0, m2r = 0;
        bit irw = 0, sa = 0, rw = 0, rd = 0, ill = 0;
        logic [1:0] aop = 2'b00, sb = 2'b00, pcs = 2'b00;
        case (st)
            1: begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
            2: begin sb = 2'b11; ill = !legal(op); end
            3: begin sa = 1; sb = 2'b10; end
            4: begin mr = 1; iord = 1; end
            5: begin rw = 1; m2r = 1; end
            6: begin mw = 1; iord = 1; end
            7: begin sa = 1; aop = 2'b10; end
            8: begin rw = 1; rd = 1; end
            9: begin sa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
            10: begin pw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {pw, pwc, iord, mr, mw, m2r, irw, sa, rw, rd, aop, sb, pcs, ill};
    endfunction

    // Drive one cycle's inputs, check state and outputs, advance one edge.
    task automatic do_step(input step_t s);
        op_code   = s.op;
        mem_ready = s.rdy;
        #1;
        check_val($sformatf("state(exp %0d)", s.st), 32'(state), 32'(s.st));
        check_val($sformatf("ctrl(st %0d)", s.st), 32'(observed()),
                  32'(expected(s.st, s.rdy, s.op)));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    // Expand one instruction into its expected trace.
    task automatic build_trace(input logic [5:0] op, input int fstall,
                               input int mstall, output step_t tr[$]);
        tr = {};
        for (int i = 0; i < fstall; i++) tr.push_back('{1, 1'b0, rnd_op()});
        tr.push_back('{1, 1'b1, rnd_op()});
        tr.push_back('{2, 1'($urandom), op});
        case (op)
            6'd35: begin
                tr.push_back('{3, 1'($urandom), op});
                for (int i = 0; i < mstall; i++) tr.push_back('{4, 1'b0, rnd_op()});
                tr.push_back('{4, 1'b1, rnd_op()});
                tr.push_back('{5, 1'($urandom), rnd_op()});
            end
            6'd43: begin
                tr.push_back('{3, 1'($urandom), op});
                for (int i = 0; i < mstall; i++) tr.push_back('{6, 1'b0, rnd_op()});
                tr.push_back('{6, 1'b1, rnd_op()});
            end
            6'd0: begin
                tr.push_back('{7, 1'($urandom), rnd_op()});
                tr.push_back('{8, 1'($urandom), rnd_op()});
            end
            6'd4: tr.push_back('{9, 1'($urandom), rnd_op()});
            6'd2: tr.push_back('{10, 1'($urandom), rnd_op()});
            default: ;
        endcase
    endtask

    task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall);
        step_t tr[$];
        int    base;
        build_trace(op, fstall, mstall, tr);
        base = (op == 6'd35) ? 5 : (op == 6'd43 || op == 6'd0) ? 4 :
               (op == 6'd4 || op == 6'd2) ? 3 : 2;
        if (tr.size() != base + fstall +
            ((op == 6'd35 || op == 6'd43) ? mstall : 0))
            $display("trace length inconsistency for op %0d", op);
        foreach (tr[i]) do_step(tr[i]);
    endtask

    initial begin
        step_t s;
        logic [5:0] op;

        // Reset asserted before any clock edge.
        rst_n     = 1'b0;
        op_code   = rnd_op();
        mem_ready = 1'b1;
        #3;
        check_val("reset_state", 32'(state), 32'd0);
        check_val("reset_ctrl", 32'(observed()), 32'd0);
        @(posedge clk);
        #1;
        check_val("reset_hold_state", 32'(state), 32'd0);
        rst_n = 1'b1;
        do_step('{0, 1'($urandom), rnd_op()});

        // Directed: lw, sw with write stall, beq, j, R-type, illegal,
        // lw with fetch stall.
        run_instr(6'd35, 0, 0);
        run_instr(6'd43, 0, 3);
        run_instr(6'd4,  0, 0);
        run_instr(6'd2,  0, 0);
        run_instr(6'd0,  0, 0);
        run_instr(6'd63, 0, 0);
        run_instr(6'd35, 2, 2);

        // Asynchronous reset in the middle of a stalled MEM_READ.
        do_step('{1, 1'b1, rnd_op()});
        do_step('{2, 1'b1, 6'd35});
        do_step('{3, 1'b1, 6'd35});
        op_code   = rnd_op();
        mem_ready = 1'b0;
        #1;
        check_val("pre_reset_state", 32'(state), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_reset_state", 32'(state), 32'd0);
        check_val("async_reset_ctrl", 32'(observed()), 32'd0);
        @(posedge clk);
        #1;
        check_val("async_reset_hold", 32'(state), 32'd0);
        rst_n = 1'b1;
        do_step('{0, 1'b0, rnd_op()});

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0: op = 6'd35;
                1: op = 6'd43;
                2: op = 6'd0;
                3: op = 6'd4;
                4: op = 6'd2;
                default: begin
                    op = rnd_op();
                    while (legal(op)) op = rnd_op();
                end
            endcase
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
